// File: rtl/meta_bram_arbiter.sv
// meta_bram_arbiter
//   Shares the single-port sparse-metadata BRAM (row_ptr / col_idx) between N_RD read
//   requesters and one DMA write port. Round-robin grant over N_RD+1 slots (reads 0..N_RD-1,
//   write N_RD). Returned read words are routed through a {valid, port id} tag pipeline into a
//   per-port holding register that the requester drains with a valid/ready handshake.
//
// Optional feature: define META_ARB_STATS_EN to build per-port saturating stall counters.
//   When undefined, stall_cnt is tied to zero.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop all in-flight and held read responses, no grant this cycle
//   rd_req/rd_addr        per-port read request and address (port i at [i*AW +: AW])
//   rd_gnt                read accepted this cycle (combinational)
//   rd_rvalid/rd_rdata    held response per port (port i at [i*DW +: DW])
//   rd_rready             requester takes the held response
//   wr_req/addr/data      DMA write request; wr_gnt accepts it (combinational)
//   bram_*                BRAM drive; bram_rdata valid READ_LAT cycles after a read enable
//   busy                  any read in flight or any response held
//   stall_cnt             per-port stall counters, 16 bits each
module meta_bram_arbiter #(
  parameter int unsigned N_RD     = 2,
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [N_RD-1:0]    rd_req,
  input  logic [N_RD*AW-1:0] rd_addr,
  output logic [N_RD-1:0]    rd_gnt,
  output logic [N_RD-1:0]    rd_rvalid,
  output logic [N_RD*DW-1:0] rd_rdata,
  input  logic [N_RD-1:0]    rd_rready,
  input  logic               wr_req,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic               wr_gnt,
  output logic               bram_en,
  output logic               bram_we,
  output logic [AW-1:0]      bram_addr,
  output logic [DW-1:0]      bram_wdata,
  input  logic [DW-1:0]      bram_rdata,
  output logic               busy,
  output logic [N_RD*16-1:0] stall_cnt
);

  localparam int unsigned NS  = N_RD + 1;
  localparam int unsigned RRW = $clog2(NS);
  localparam int unsigned IDW = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam logic [RRW-1:0] WR_SLOT = RRW'(N_RD);

  logic [RRW-1:0]      r_rr;
  logic [READ_LAT-1:0] r_tag_v;
  logic [IDW-1:0]      r_tag_id [READ_LAT];
  logic [N_RD-1:0]     r_rvalid;
  logic [N_RD*DW-1:0]  r_rdata;

  logic [N_RD-1:0] w_inflight;
  logic [NS-1:0]   w_elig;
  logic            w_found;
  logic [RRW-1:0]  w_win;
  logic [N_RD-1:0] w_rd_gnt;
  logic            w_wr_gnt;
  logic [IDW-1:0]  w_rd_id;

  // A port is in flight while any tag stage carries its id.
  always_comb begin
    w_inflight = '0;
    for (int j = 0; j < READ_LAT; j++) begin
      for (int i = 0; i < N_RD; i++) begin
        if (r_tag_v[j] && (r_tag_id[j] == IDW'(i))) w_inflight[i] = 1'b1;
      end
    end
  end

  // Flush suppresses every grant, including a pending write.
  always_comb begin
    w_elig[N_RD-1:0] = rd_req & ~w_inflight & ~r_rvalid & {N_RD{~flush}};
    w_elig[N_RD]     = wr_req & ~flush;
  end

  // Rotating priority: scan slots rr..NS-1 first, then 0..rr-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int s = 0; s < NS; s++) begin
      if (!w_found && (s >= int'(r_rr)) && w_elig[s]) begin
        w_found = 1'b1;
        w_win   = RRW'(s);
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (!w_found && (s < int'(r_rr)) && w_elig[s]) begin
        w_found = 1'b1;
        w_win   = RRW'(s);
      end
    end
  end

  always_comb begin
    w_rd_gnt = '0;
    w_rd_id  = '0;
    for (int i = 0; i < N_RD; i++) begin
      if (w_found && (w_win == RRW'(i))) begin
        w_rd_gnt[i] = 1'b1;
        w_rd_id     = IDW'(i);
      end
    end
    w_wr_gnt = w_found && (w_win == WR_SLOT);
  end

  always_comb begin
    bram_en    = w_found;
    bram_we    = w_wr_gnt;
    bram_addr  = '0;
    bram_wdata = '0;
    if (w_wr_gnt) begin
      bram_addr  = wr_addr;
      bram_wdata = wr_data;
    end
    for (int i = 0; i < N_RD; i++) begin
      if (w_rd_gnt[i]) bram_addr = rd_addr[i*AW +: AW];
    end
  end

  assign rd_gnt    = w_rd_gnt;
  assign wr_gnt    = w_wr_gnt;
  assign rd_rvalid = r_rvalid;
  assign rd_rdata  = r_rdata;
  assign busy      = (|r_tag_v) | (|r_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_found) begin
      r_rr <= (w_win == WR_SLOT) ? '0 : w_win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      for (int j = 0; j < READ_LAT; j++) r_tag_id[j] <= '0;
    end else begin
      r_tag_v[0]  <= (|w_rd_gnt) & ~flush;
      r_tag_id[0] <= w_rd_id;
      for (int j = 1; j < READ_LAT; j++) begin
        r_tag_v[j]  <= r_tag_v[j-1] & ~flush;
        r_tag_id[j] <= r_tag_id[j-1];
      end
    end
  end

  // The returning port can never hold a response (it was ineligible), so capture and consume
  // never collide on the same port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else if (flush) begin
      r_rvalid <= '0;
    end else begin
      for (int i = 0; i < N_RD; i++) begin
        if (r_rvalid[i] && rd_rready[i]) r_rvalid[i] <= 1'b0;
        if (r_tag_v[READ_LAT-1] && (r_tag_id[READ_LAT-1] == IDW'(i))) begin
          r_rvalid[i]            <= 1'b1;
          r_rdata[i*DW +: DW]    <= bram_rdata;
        end
      end
    end
  end

`ifdef META_ARB_STATS_EN
  logic [15:0] r_stall [N_RD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_RD; i++) r_stall[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_RD; i++) r_stall[i] <= '0;
    end else begin
      for (int i = 0; i < N_RD; i++) begin
        if (rd_req[i] && !w_rd_gnt[i] && (r_stall[i] != 16'hFFFF)) begin
          r_stall[i] <= r_stall[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt = '0;
    for (int i = 0; i < N_RD; i++) stall_cnt[i*16 +: 16] = r_stall[i];
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_meta_bram_arbiter.sv
// Self-checking bench for meta_bram_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model (per-port countdowns,
// held responses and a shadow copy of the metadata memory).
module tb_meta_bram_arbiter;

  localparam int N_RD     = 3;
  localparam int AW       = 12;
  localparam int DW       = 32;
  localparam int READ_LAT = 2;
  localparam int NS       = N_RD + 1;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic [N_RD-1:0]    rd_req;
  logic [N_RD*AW-1:0] rd_addr;
  logic [N_RD-1:0]    rd_gnt;
  logic [N_RD-1:0]    rd_rvalid;
  logic [N_RD*DW-1:0] rd_rdata;
  logic [N_RD-1:0]    rd_rready;
  logic               wr_req;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               wr_gnt;
  logic               bram_en;
  logic               bram_we;
  logic [AW-1:0]      bram_addr;
  logic [DW-1:0]      bram_wdata;
  logic [DW-1:0]      bram_rdata;
  logic               busy;
  logic [N_RD*16-1:0] stall_cnt;

  meta_bram_arbiter #(
    .N_RD(N_RD), .AW(AW), .DW(DW), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_rready(rd_rready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device model of the BRAM itself.
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
    if (bram_en && !bram_we) rd_pipe[0] <= mem[bram_addr];
    for (int j = 1; j < READ_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
  end
  assign bram_rdata = rd_pipe[READ_LAT-1];

  // Reference model state.
  int            m_rr;
  int            m_pend [N_RD];
  logic          m_held [N_RD];
  logic [DW-1:0] m_hdata [N_RD];
  logic [DW-1:0] m_pdata [N_RD];
  int            m_stall [N_RD];
  logic [DW-1:0] shadow [1 << AW];
  int            e_win;

  int n_checks;
  int n_errors;
  logic [N_RD:0] obs_gnt;
  logic          obs_rv0;
  logic [DW-1:0] obs_rd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < N_RD; i++) begin
      m_pend[i] = 0; m_held[i] = 1'b0; m_hdata[i] = '0; m_pdata[i] = '0; m_stall[i] = 0;
    end
  endtask

  function automatic bit slot_eligible(input int s);
    if (flush) return 1'b0;
    if (s == N_RD) return wr_req;
    return rd_req[s] && (m_pend[s] == 0) && !m_held[s];
  endfunction

  task automatic model_comb();
    e_win = -1;
    for (int k = 0; k < NS; k++) begin
      int s;
      s = (m_rr + k) % NS;
      if (e_win < 0 && slot_eligible(s)) e_win = s;
    end
  endtask

  task automatic compare_all();
    logic [N_RD-1:0] e_rdg;
    logic [N_RD-1:0] e_rv;
    logic [AW-1:0]   e_addr;
    logic            e_busy;
    e_rdg  = '0;
    e_rv   = '0;
    e_busy = 1'b0;
    e_addr = '0;
    if (e_win >= 0 && e_win < N_RD) begin
      e_rdg[e_win] = 1'b1;
      e_addr = rd_addr[e_win*AW +: AW];
    end
    if (e_win == N_RD) e_addr = wr_addr;
    for (int i = 0; i < N_RD; i++) begin
      e_rv[i] = m_held[i];
      if (m_held[i] || m_pend[i] > 0) e_busy = 1'b1;
    end
    check("rd_gnt", 64'(rd_gnt), 64'(e_rdg));
    check("wr_gnt", 64'(wr_gnt), 64'(e_win == N_RD));
    check("bram_en", 64'(bram_en), 64'(e_win >= 0));
    check("bram_we", 64'(bram_we), 64'(e_win == N_RD));
    check("bram_addr", 64'(bram_addr), 64'(e_addr));
    check("bram_wdata", 64'(bram_wdata), (e_win == N_RD) ? 64'(wr_data) : 64'd0);
    check("rd_rvalid", 64'(rd_rvalid), 64'(e_rv));
    for (int i = 0; i < N_RD; i++) begin
      check($sformatf("rd_rdata%0d", i), 64'(rd_rdata[i*DW +: DW]), 64'(m_hdata[i]));
`ifdef META_ARB_STATS_EN
      check($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i*16 +: 16]), 64'(m_stall[i]));
`else
      check($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i*16 +: 16]), 64'd0);
`endif
    end
    check("busy", 64'(busy), 64'(e_busy));
    obs_gnt = {wr_gnt, rd_gnt};
    obs_rv0 = rd_rvalid[0];
    obs_rd0 = rd_rdata[DW-1:0];
  endtask

  task automatic model_update();
    if (flush) begin
      for (int i = 0; i < N_RD; i++) begin
        m_pend[i] = 0; m_held[i] = 1'b0; m_stall[i] = 0;
      end
      return;
    end
    for (int i = 0; i < N_RD; i++) begin
      if (m_held[i] && rd_rready[i]) m_held[i] = 1'b0;
      if (m_pend[i] > 0) begin
        m_pend[i]--;
        if (m_pend[i] == 0) begin
          m_held[i]  = 1'b1;
          m_hdata[i] = m_pdata[i];
        end
      end
      if (rd_req[i] && !(e_win == i) && m_stall[i] < 16'hFFFF) m_stall[i]++;
    end
    if (e_win == N_RD) begin
      shadow[wr_addr] = wr_data;
    end else if (e_win >= 0) begin
      m_pend[e_win]  = READ_LAT;
      m_pdata[e_win] = shadow[rd_addr[e_win*AW +: AW]];
    end
    if (e_win >= 0) m_rr = (e_win + 1) % NS;
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic cycle();
    model_comb();
    #3;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; rd_req = '0; rd_addr = '0; rd_rready = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    model_comb();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    idle_inputs();
    rd_rready = '1;
    repeat (READ_LAT + 3) cycle();
    rd_rready = '0;
  endtask

  task automatic drive_random();
    flush = ($urandom_range(0, 39) == 0);
    for (int i = 0; i < N_RD; i++) begin
      rd_req[i]            = ($urandom_range(0, 1) == 1);
      rd_rready[i]         = ($urandom_range(0, 2) != 0);
      rd_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
    end
    wr_req  = ($urandom_range(0, 3) == 0);
    wr_addr = AW'($urandom_range(0, 15));
    wr_data = $urandom;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]    = 32'hA000_0000 + a;
      shadow[a] = 32'hA000_0000 + a;
    end
    for (int j = 0; j < READ_LAT; j++) rd_pipe[j] = '0;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Contention from rr=0: port0, port1, then the write.
    rd_req = 3'b011; wr_req = 1'b1; wr_addr = 12'd3; wr_data = 32'h1234_5678;
    cycle(); check("contention_c0", 64'(obs_gnt), 64'b0001);
    cycle(); check("contention_c1", 64'(obs_gnt), 64'b0010);
    cycle(); check("contention_c2", 64'(obs_gnt), 64'b1000);
    drain();

    // Single read of a freshly written word, then held while rready is low.
    wr_req = 1'b1; wr_addr = 12'd7; wr_data = 32'hDEAD_0005;
    cycle();
    idle_inputs();
    rd_req[0] = 1'b1; rd_addr[AW-1:0] = 12'd7;
    cycle(); check("single_gnt", 64'(obs_gnt), 64'b0001);
    rd_req[0] = 1'b0;
    repeat (READ_LAT) cycle();
    check("single_not_yet", 64'(obs_rv0), 64'd0);
    repeat (4) begin
      cycle();
      check("single_rvalid", 64'(obs_rv0), 64'd1);
      check("single_rdata", 64'(obs_rd0), 64'hDEAD_0005);
    end
    drain();

    // Flush one cycle after a grant: no response ever, busy clears.
    rd_req[0] = 1'b1; rd_addr[AW-1:0] = 12'd9;
    cycle();
    rd_req[0] = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle(); check("flush_busy", 64'(busy), 64'd0);
    repeat (READ_LAT + 2) begin
      cycle(); check("flush_no_rvalid", 64'(obs_rv0), 64'd0);
    end

    // Randomized traffic with an occasional mid-operation reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive_random();
        cycle();
      end
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/meta_bram_arbiter.md
Name: meta_bram_arbiter

Overview:
- Shares the single-port sparse-metadata BRAM (row_ptr and col_idx arrays) between N_RD read requesters (BSR scheduler, CSR/debug readback, ...) and one DMA write port that loads metadata.
- Round-robin grant, with a tagged read-latency pipeline that routes each returned word to its requester.
- Each port gets a response holding register with valid/ready handshake, so a requester may stall while taking the response.

Parameters:
- N_RD, 2, number of read requester ports (1..8).
- AW, 12, metadata BRAM word-address width.
- DW, 32, data width.
- READ_LAT, 1, BRAM read latency in cycles (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  drop all in-flight and held read responses
- rd_req  in  N_RD  per-port read request
- rd_addr  in  N_RD*AW  per-port address; port i in bits [i*AW +: AW]
- rd_gnt  out  N_RD  request accepted this cycle (combinational)
- rd_rvalid  out  N_RD  response held valid
- rd_rdata  out  N_RD*DW  per-port response data
- rd_rready  in  N_RD  requester takes response
- wr_req  in  1  DMA write request
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_gnt  out  1  write accepted this cycle (combinational)
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  AW  BRAM address
- bram_wdata  out  DW  BRAM write data
- bram_rdata  in  DW  BRAM read data, valid READ_LAT cycles after bram_en with bram_we=0
- busy  out  1  any read in flight or any response held
- stall_cnt  out  N_RD*16  per-port stall counters (see Optional Feature)

Behaviour:
- Slots 0..N_RD-1 are the read ports; slot N_RD is the write port.
- Read port i is eligible when rd_req[i]=1 and port i has no in-flight read and no held response. Each port has at most 1 outstanding read.
- The write port is eligible when wr_req=1.
- Round-robin pointer rr (reset 0). Winner = first eligible slot starting at rr, wrapping. rr <= winner+1 (mod N_RD+1) only on a grant; otherwise rr holds.
- Exactly one of rd_gnt/wr_gnt is high per cycle, or none. Grant is combinational and is the ready of a valid/ready handshake: the transfer happens when req and gnt are both high in the same cycle.
- BRAM drive is combinational from the winner in the same cycle:
  - bram_en=1, bram_we=1 for a write;
  - bram_addr/bram_wdata from the winner;
  - with no grant: bram_en=0, bram_we=0, addr/wdata=0.
- Tag pipeline, READ_LAT stages of {valid, port id}. A read grant in cycle t captures bram_rdata into port i's holding register at the end of cycle t+READ_LAT. rd_rvalid[i]=1 from cycle t+READ_LAT+1 until rd_rready[i]=1 is seen.
- Port i is eligible again in the cycle after the response is consumed. Minimum per-port issue interval is READ_LAT+2 cycles.
- Different ports may have reads in flight back-to-back, one grant per cycle. The holding register for a tagged port is always free on return, so capture never conflicts.
- Write/read ordering to the same address follows grant order. A read granted after a write returns the new data (BRAM write-first or read-first does not matter at a later cycle).
- flush:
  - In the flush cycle: all tag valids <= 0, all rd_rvalid <= 0, no grants issued.
  - rr is unchanged.
  - A write granted in the same cycle as flush is not issued.
- Simultaneous rd_rready and a new rd_req on the same port in one cycle: the response is consumed, and the request waits until the next cycle.
- busy = |tag valids | |rd_rvalid.
- Reset values: rd_rvalid=0, rd_rdata=0, tag pipeline empty, rr=0, busy=0, stall_cnt=0. Grant and bram outputs are 0 while no requests are present.
- Reset mid-operation: in-flight reads are discarded with no response; the BRAM contents are untouched.

Optional Feature:
- Macro META_ARB_STATS_EN.
- Defined: stall_cnt[i] increments (saturating at 16'hFFFF) each cycle rd_req[i]=1 and rd_gnt[i]=0. Cleared by reset and flush.
- Not defined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Single read: DMA writes 0xDEAD_0005 to addr 7; port0 reads addr 7 with READ_LAT=1 -> rd_gnt[0] at t, rd_rvalid[0] at t+2, rd_rdata=0xDEAD_0005; held 3 cycles while rd_rready=0.
- Contention: port0, port1 and wr_req all high from rr=0 -> grant order port0, port1, write; write granted at cycle 2; rr=0 afterward.
- Back-to-back ports: port0 reads addr 1 (=10), port1 reads addr 2 (=20) in consecutive cycles -> rvalid[0] with 10 and rvalid[1] with 20, one cycle apart, with no cross-routing.
- Outstanding limit: port0 holds rd_req=1 with rd_rready=0 -> only one grant; second grant only the cycle after rd_rready=1.
- Flush: read granted at t, flush at t+1 -> no rd_rvalid ever; busy=0 at t+2; next read returns correct data.
- Stats (META_ARB_STATS_EN): port1 blocked 5 cycles by port0/write traffic -> stall_cnt[1]=5. Macro undefined -> stall_cnt stays 0.
